// File: rtl/metronome_pkg.sv
// metronome_pkg: shared tempo defaults, period/BPM helpers and the beat FSM state type
package metronome_pkg;
  localparam int BPM_MIN_DEF = 60;
  localparam int BPM_STEP_DEF = 15;
  typedef enum logic {STOPPED, RUNNING} state_t;
  function automatic longint period_cycles(input longint clk_hz, input int bpm_min, input int bpm_step, input int sel);
    return (clk_hz * 60) / longint'(bpm_min + bpm_step * sel);
  endfunction
  function automatic logic [8:0] bpm_of(input int bpm_min, input int bpm_step, input logic [3:0] sel);
    return 9'(bpm_min + bpm_step * int'(sel));
  endfunction
endpackage

// File: rtl/beat_scheduler_if.sv
// beat_scheduler_if: control inputs and beat/flash outputs between board, VGA timing and pixel logic
interface beat_scheduler_if #(parameter int IDX_W = 2);
  logic run;
  logic [3:0] sw;
  logic frame_start;
  logic beat_tick;
  logic [IDX_W-1:0] beat_idx;
  logic accent;
  logic flash_on;
  logic flash_vis;
  logic accent_vis;
  logic [8:0] tempo_bpm;
  logic tempo_pending;
  modport master (
    output run, sw, frame_start,
    input beat_tick, beat_idx, accent, flash_on, flash_vis, accent_vis, tempo_bpm, tempo_pending
  );
  modport slave (
    input run, sw, frame_start,
    output beat_tick, beat_idx, accent, flash_on, flash_vis, accent_vis, tempo_bpm, tempo_pending
  );
endinterface

// File: rtl/sync_debounce.sv
// sync_debounce: 2-FF synchronizer with a saturating stability counter on the synchronized value
module sync_debounce #(
  parameter int WIDTH = 4,
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             stable
);
  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  logic [WIDTH-1:0] s1;
  logic [CW-1:0] cnt;
  assign stable = cnt == CW'(DEBOUNCE_CYC);
  // two-stage synchronizer for the asynchronous input
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q, s1} <= '0;
    else {q, s1} <= {s1, d};
  // restart the count on the edge where q takes a new value, saturate once stable
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= s1 != q ? '0 : stable ? cnt : cnt + 1'b1;
endmodule

// File: rtl/beat_scheduler.sv
// beat_scheduler: metronome beat timing, tempo selection and frame-aligned flash/accent
module beat_scheduler import metronome_pkg::*; #(
  parameter int CLK_HZ = 100_000_000,
  parameter int BPM_MIN = BPM_MIN_DEF,
  parameter int BPM_STEP = BPM_STEP_DEF,
  parameter int BEATS_PER_BAR = 4,
  parameter int FLASH_MS = 100,
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input logic clk_100MHz,
  input logic reset,
  beat_scheduler_if.slave bus
);
  localparam longint P0 = period_cycles(CLK_HZ, BPM_MIN, BPM_STEP, 0);
  localparam longint P15 = period_cycles(CLK_HZ, BPM_MIN, BPM_STEP, 15);
  localparam int PW = $clog2(P0);
  localparam longint FLASH_CYC = longint'(CLK_HZ) * FLASH_MS / 1000;
  localparam int FW = $clog2(FLASH_CYC + 1);
  localparam int IW = BEATS_PER_BAR > 1 ? $clog2(BEATS_PER_BAR) : 1;
  state_t state, state_n;
  logic run_s1, run_s, sw_stable, start, stop, wrap, beat_tick_r, acc_r, pending, fvis, avis, flash_on;
  logic [3:0] sw_s, active_sel, pend_sel;
  logic [PW-1:0] phase, period;
  logic [PW-1:0] period_lut [16];
  logic [IW-1:0] idx, idx_nx;
  logic [FW-1:0] flash_cnt;
  for (genvar s = 0; s < 16; s++) begin : g_lut
    localparam longint P = period_cycles(CLK_HZ, BPM_MIN, BPM_STEP, s);
    assign period_lut[s] = PW'(P);
  end
  sync_debounce #(.WIDTH(4), .DEBOUNCE_CYC(DEBOUNCE_CYC)) u_sw (
    .clk(clk_100MHz), .rst_n(reset), .d(bus.sw), .q(sw_s), .stable(sw_stable)
  );
  assign period = period_lut[active_sel];
  assign idx_nx = idx == IW'(BEATS_PER_BAR - 1) ? '0 : idx + 1'b1;
  assign flash_on = flash_cnt != '0;
  // two-stage synchronizer for run
  always_ff @(posedge clk_100MHz or negedge reset)
    if (!reset) {run_s, run_s1} <= '0;
    else {run_s, run_s1} <= {run_s1, bus.run};
  // FSM state register
  always_ff @(posedge clk_100MHz or negedge reset)
    if (!reset) state <= STOPPED;
    else state <= state_n;
  // next state and beat events; stopping takes priority over a wrap
  always_comb begin
    start = state == STOPPED && run_s;
    stop = state == RUNNING && !run_s;
    wrap = state == RUNNING && run_s && phase == period - 1'b1;
    state_n = start ? RUNNING : stop ? STOPPED : state;
  end
  // phase counter, tick pulse, bar index, accent flag and flash window
  always_ff @(posedge clk_100MHz or negedge reset)
    if (!reset) begin
      phase <= '0;
      beat_tick_r <= 1'b0;
      idx <= '0;
      acc_r <= 1'b0;
      flash_cnt <= '0;
    end else begin
      phase <= state_n == RUNNING && !start && !wrap ? phase + 1'b1 : '0;
      beat_tick_r <= start || wrap;
      idx <= start || stop ? '0 : wrap ? idx_nx : idx;
      acc_r <= start ? 1'b1 : wrap ? idx_nx == '0 : stop ? 1'b0 : acc_r;
      flash_cnt <= start || wrap ? FW'(FLASH_CYC) : stop ? '0 : flash_on ? flash_cnt - 1'b1 : flash_cnt;
    end
  // tempo selection: debounced code becomes pending, applied when stopped or at the beat wrap
  always_ff @(posedge clk_100MHz or negedge reset)
    if (!reset) begin
      active_sel <= '0;
      pend_sel <= '0;
      pending <= 1'b0;
    end else if (pending && (state == STOPPED || wrap)) begin
      active_sel <= pend_sel;
      pending <= 1'b0;
    end else if (sw_stable && sw_s != active_sel) begin
      pend_sel <= sw_s;
      pending <= 1'b1;
    end else if (sw_s == active_sel) pending <= 1'b0;
  // pixel-side copies change only at frame start so colours never switch mid-frame
  always_ff @(posedge clk_100MHz or negedge reset)
    if (!reset) {fvis, avis} <= '0;
    else if (bus.frame_start) {fvis, avis} <= {flash_on, acc_r && flash_on};
  // the flash window must end before the fastest beat can restart it
  always_ff @(posedge clk_100MHz)
    assert (FLASH_CYC < P15) else $error("flash window not shorter than fastest beat period");
  assign bus.beat_tick = beat_tick_r;
  assign bus.beat_idx = idx;
  assign bus.accent = acc_r && flash_on;
  assign bus.flash_on = flash_on;
  assign bus.flash_vis = fvis;
  assign bus.accent_vis = avis;
  assign bus.tempo_bpm = bpm_of(BPM_MIN, BPM_STEP, active_sel);
  assign bus.tempo_pending = pending;
endmodule

// File: tb/tb_beat_scheduler.sv
// tb_beat_scheduler: tick scoreboard, tempo table and corner-case sequences for beat_scheduler
module tb_beat_scheduler;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  beat_scheduler_if #(.IDX_W(2)) bus();
  beat_scheduler #(.CLK_HZ(1200), .DEBOUNCE_CYC(16), .FLASH_MS(100)) dut (
    .clk_100MHz(clk), .reset(reset), .bus(bus.slave)
  );
  typedef struct { int at; int idx; int acc; int bpm; } tick_t;
  typedef struct { int sel; int bpm; int period; int nt; } row_t;
  tick_t exp_q[$];
  int cyc = 0;
  int nchk = 0;
  int npass = 0;
  int flash_end = -1;
  int fl_prev = 0, ac_prev = 0, fv_prev = 0, av_prev = 0;

  task automatic check(input string nm, input int act, input int exp);
    nchk++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic push(input int at, input int idx, input int bpm);
    tick_t e;
    e.at = at;
    e.idx = idx;
    e.acc = idx == 0 ? 1 : 0;
    e.bpm = bpm;
    exp_q.push_back(e);
  endtask

  task automatic step();
    tick_t e;
    @(negedge clk);
    cyc++;
    while (exp_q.size() != 0 && exp_q[0].at < cyc) begin
      e = exp_q.pop_front();
      check("missed_tick_cycle", cyc, e.at);
    end
    if (bus.beat_tick) begin
      if (exp_q.size() == 0) check("unexpected_tick_idx", int'(bus.beat_idx), -1);
      else begin
        e = exp_q.pop_front();
        check("tick_cycle", cyc, e.at);
        check("tick_idx", int'(bus.beat_idx), e.idx);
        check("tick_accent", int'(bus.accent), e.acc);
        check("tick_flash_on", int'(bus.flash_on), 1);
        check("tick_bpm", int'(bus.tempo_bpm), e.bpm);
        flash_end = cyc + 120;
      end
    end
    if (cyc == flash_end - 1) check("flash_last_cycle", int'(bus.flash_on), 1);
    if (cyc == flash_end) begin
      check("flash_expired", int'(bus.flash_on), 0);
      check("accent_expired", int'(bus.accent), 0);
    end
    if (reset) begin
      check("flash_vis", int'(bus.flash_vis), bus.frame_start ? fl_prev : fv_prev);
      check("accent_vis", int'(bus.accent_vis), bus.frame_start ? ac_prev : av_prev);
    end
    fl_prev = int'(bus.flash_on);
    ac_prev = int'(bus.accent);
    fv_prev = int'(bus.flash_vis);
    av_prev = int'(bus.accent_vis);
    bus.frame_start = cyc % 50 == 0;
  endtask

  task automatic wait_q(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check("ticks_outstanding", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_beat_tick"}, int'(bus.beat_tick), 0);
    check({tag, "_beat_idx"}, int'(bus.beat_idx), 0);
    check({tag, "_accent"}, int'(bus.accent), 0);
    check({tag, "_flash_on"}, int'(bus.flash_on), 0);
    check({tag, "_flash_vis"}, int'(bus.flash_vis), 0);
    check({tag, "_accent_vis"}, int'(bus.accent_vis), 0);
    check({tag, "_tempo_bpm"}, int'(bus.tempo_bpm), 60);
    check({tag, "_tempo_pending"}, int'(bus.tempo_pending), 0);
  endtask

  initial begin
    row_t rows[5];
    int c, t, u;
    rows[0] = '{0, 60, 1200, 5};
    rows[1] = '{4, 120, 600, 3};
    rows[2] = '{15, 285, 252, 3};
    rows[3] = '{7, 165, 436, 3};
    rows[4] = '{1, 75, 960, 3};
    bus.run = 1'b0;
    bus.sw = 4'd0;
    bus.frame_start = 1'b0;
    repeat (3) step();
    check_idle("reset");
    reset = 1'b1;
    repeat (5) step();
    foreach (rows[i]) begin
      bus.run = 1'b0;
      flash_end = -1;
      bus.sw = 4'(rows[i].sel);
      repeat (30) step();
      check("stopped_bpm", int'(bus.tempo_bpm), rows[i].bpm);
      check("stopped_pending", int'(bus.tempo_pending), 0);
      check("stopped_idx", int'(bus.beat_idx), 0);
      check("stopped_flash", int'(bus.flash_on), 0);
      bus.run = 1'b1;
      c = cyc;
      for (int k = 0; k < rows[i].nt; k++) push(c + 3 + k * rows[i].period, k % 4, rows[i].bpm);
      wait_q(rows[i].nt * rows[i].period + 10);
    end
    bus.run = 1'b0;
    flash_end = -1;
    bus.sw = 4'd0;
    repeat (30) step();
    check("back_to_60", int'(bus.tempo_bpm), 60);
    bus.run = 1'b1;
    c = cyc;
    push(c + 3, 0, 60);
    push(c + 1203, 1, 120);
    push(c + 1803, 2, 120);
    push(c + 2403, 3, 120);
    repeat (300) step();
    bus.sw = 4'd4;
    repeat (17) step();
    check("pending_not_early", int'(bus.tempo_pending), 0);
    repeat (3) step();
    check("pending_set", int'(bus.tempo_pending), 1);
    check("bpm_held_until_wrap", int'(bus.tempo_bpm), 60);
    wait_q(2600);
    check("pending_cleared", int'(bus.tempo_pending), 0);
    t = cyc;
    push(t + 600, 0, 120);
    push(t + 1200, 1, 120);
    repeat (100) step();
    bus.sw = 4'd15;
    repeat (5) step();
    bus.sw = 4'd4;
    repeat (30) step();
    check("glitch_pending", int'(bus.tempo_pending), 0);
    check("glitch_bpm", int'(bus.tempo_bpm), 120);
    wait_q(1300);
    t = cyc;
    repeat (50) step();
    bus.sw = 4'd15;
    repeat (25) step();
    check("pending_285", int'(bus.tempo_pending), 1);
    push(t + 600, 2, 285);
    push(t + 852, 3, 285);
    push(t + 1104, 0, 285);
    push(t + 1356, 1, 285);
    wait_q(1500);
    check("pending_285_cleared", int'(bus.tempo_pending), 0);
    u = cyc;
    while (cyc < u + 249) step();
    bus.run = 1'b0;
    flash_end = -1;
    repeat (3) step();
    check("stop_on_wrap_tick", int'(bus.beat_tick), 0);
    check("stop_on_wrap_idx", int'(bus.beat_idx), 0);
    check("stop_on_wrap_flash", int'(bus.flash_on), 0);
    check("stop_on_wrap_accent", int'(bus.accent), 0);
    repeat (20) step();
    bus.run = 1'b1;
    c = cyc;
    push(c + 3, 0, 285);
    push(c + 255, 1, 285);
    wait_q(300);
    repeat (100) step();
    check("pre_reset_flash", int'(bus.flash_on), 1);
    #3 reset = 1'b0;
    flash_end = -1;
    #1 check_idle("async_reset");
    repeat (5) step();
    reset = 1'b1;
    c = cyc;
    push(c + 3, 0, 60);
    push(c + 1203, 1, 285);
    push(c + 1455, 2, 285);
    wait_q(1600);
    bus.run = 1'b0;
    flash_end = -1;
    repeat (10) step();
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
